// File: rtl/regfile_scoreboard.sv
// Register file with RAW-hazard busy scoreboard; optional write-through forwarding under BYPASS_EN.
// Latency: reads zero-cycle combinational; writes, busy bits and busy_cnt update on the next clk edge.
// Backpressure: none; decode stalls on rs_busy/rt_busy, and every writeback/issue is accepted.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              regWrite,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt_nxt;
  logic              wr_en;
  logic              iss_en;

  // With a hard-wired zero register, index 0 is invisible to both data and scoreboard.
  assign wr_en  = regWrite    && !(ZERO_REG && (rd == '0));
  assign iss_en = issue_valid && !(ZERO_REG && (issue_rd == '0));

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) begin
      busy_nxt[rd] = 1'b0;
    end
    if (iss_en) begin
      busy_nxt[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_nxt = busy_cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  always_comb begin
    A = regs[rs];
    if (ZERO_REG && (rs == '0)) begin
      A = '0;
    end
`ifdef BYPASS_EN
    // Forward is held off during reset so outputs read zero there.
    if (rst_n && wr_en && (rd == rs)) begin
      A = write_data;
    end
`endif
  end

  always_comb begin
    B = regs[rt];
    if (ZERO_REG && (rt == '0)) begin
      B = '0;
    end
`ifdef BYPASS_EN
    if (rst_n && wr_en && (rd == rt)) begin
      B = write_data;
    end
`endif
  end

  always_comb begin
    rs_busy = busy[rs];
`ifdef BYPASS_EN
    if (wr_en && (rd == rs) && !(iss_en && (issue_rd == rs))) begin
      rs_busy = 1'b0;
    end
`endif
  end

  always_comb begin
    rt_busy = busy[rt];
`ifdef BYPASS_EN
    if (wr_en && (rd == rt) && !(iss_en && (issue_rd == rt))) begin
      rt_busy = 1'b0;
    end
`endif
  end

  a_cnt_matches_vector: assert property (@(posedge clk) disable iff (!rst_n)
    busy_cnt == (ADDR_W+1)'($countones(busy)));

  a_zero_never_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(ZERO_REG && busy[0]));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus,
// an array model is checked every negedge, and directed literals pin the model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, rd, issue_rd;
  logic [31:0] write_data;
  logic        regWrite, issue_valid;

  logic [31:0] a1, b1, a0, b0;
  logic        rsb1, rtb1, rsb0, rtb0;
  logic [5:0]  cnt1, cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_dut_zr (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .A(a1), .B(b1),
    .rd(rd), .write_data(write_data), .regWrite(regWrite),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs_busy(rsb1), .rt_busy(rtb1), .busy_cnt(cnt1)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) u_dut_plain (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .A(a0), .B(b0),
    .rd(rd), .write_data(write_data), .regWrite(regWrite),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs_busy(rsb0), .rt_busy(rtb0), .busy_cnt(cnt0)
  );

  // Model state: index 1 mirrors the ZERO_REG=1 instance, index 0 the ordinary one.
  logic [31:0] mregs [2][32];
  bit          mbusy [2][32];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) begin
          mregs[k][i] <= 32'h0;
          mbusy[k][i] <= 1'b0;
        end
      end else begin
        if (regWrite && !(k == 1 && rd == 5'd0)) begin
          mregs[k][rd] <= write_data;
          mbusy[k][rd] <= 1'b0;
        end
        if (issue_valid && !(k == 1 && issue_rd == 5'd0)) begin
          mbusy[k][issue_rd] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(input int k, input int idx);
    if (k == 1 && idx == 0) return 32'h0;
`ifdef BYPASS_EN
    if (rst_n && regWrite && int'(rd) == idx && !(k == 1 && rd == 5'd0)) return write_data;
`endif
    return mregs[k][idx];
  endfunction

  function automatic logic exp_busy(input int k, input int idx);
`ifdef BYPASS_EN
    if (regWrite && int'(rd) == idx && !(k == 1 && rd == 5'd0) &&
        !(issue_valid && int'(issue_rd) == idx)) return 1'b0;
`endif
    return mbusy[k][idx];
  endfunction

  function automatic int exp_cnt(input int k);
    int c = 0;
    for (int i = 0; i < 32; i++) if (mbusy[k][i]) c++;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("A_zr",     64'(a1),   64'(exp_data(1, int'(rs))));
      check("B_zr",     64'(b1),   64'(exp_data(1, int'(rt))));
      check("rsb_zr",   64'(rsb1), 64'(exp_busy(1, int'(rs))));
      check("rtb_zr",   64'(rtb1), 64'(exp_busy(1, int'(rt))));
      check("cnt_zr",   64'(cnt1), 64'(exp_cnt(1)));
      check("A_plain",  64'(a0),   64'(exp_data(0, int'(rs))));
      check("B_plain",  64'(b0),   64'(exp_data(0, int'(rt))));
      check("rsb_plain",64'(rsb0), 64'(exp_busy(0, int'(rs))));
      check("rtb_plain",64'(rtb0), 64'(exp_busy(0, int'(rt))));
      check("cnt_plain",64'(cnt0), 64'(exp_cnt(0)));
    end
  end

  // Inputs change 1 time unit after posedge; callers check literals 3 units after posedge.
  task automatic cyc(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic [4:0] i_rd,
                     input logic [31:0] i_wd, input logic i_we, input logic i_iv,
                     input logic [4:0] i_ird);
    @(posedge clk);
    #1;
    rs = i_rs; rt = i_rt; rd = i_rd; write_data = i_wd;
    regWrite = i_we; issue_valid = i_iv; issue_rd = i_ird;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    rs = 5'd5; rt = 5'd6; rd = 5'd0; write_data = 32'h0;
    regWrite = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_A",   64'(a1),   64'h0);
    check("rst_rsb", 64'(rsb1), 64'h0);
    check("rst_cnt", 64'(cnt1), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write/read
    cyc(5'd0, 5'd0, 5'd5, 32'hA5A5A5A5, 1'b1, 1'b0, 5'd0);
    cyc(5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t1_A",   64'(a1),   64'hA5A5A5A5);
    check("t1_B",   64'(b1),   64'h0);
    check("t1_cnt", 64'(cnt1), 64'h0);

    // Zero register
    cyc(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd0);
    cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t2_A_zr",    64'(a1), 64'h0);
    check("t2_A_plain", 64'(a0), 64'hFFFFFFFF);

    // Scoreboard set then clear
    cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd10);
    cyc(5'd10, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t3_busy", 64'(rsb1), 64'h1);
    check("t3_cnt",  64'(cnt1), 64'h1);
    cyc(5'd10, 5'd10, 5'd10, 32'h12345678, 1'b1, 1'b0, 5'd0);
`ifdef BYPASS_EN
    check("t3_wb_busy", 64'(rsb1), 64'h0);
    check("t3_wb_A",    64'(a1),   64'h12345678);
`else
    check("t3_wb_busy", 64'(rsb1), 64'h1);
    check("t3_wb_A",    64'(a1),   64'h0);
`endif
    cyc(5'd10, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t3_clr_busy", 64'(rsb1), 64'h0);
    check("t3_clr_cnt",  64'(cnt1), 64'h0);
    check("t3_clr_A",    64'(a1),   64'h12345678);

    // Same-cycle set and clear: set wins; re-issue to busy reg does not double count
    cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    cyc(5'd7, 5'd7, 5'd7, 32'h77, 1'b1, 1'b1, 5'd7);
    check("t4_same_cnt",  64'(cnt1), 64'h1);
    check("t4_same_busy", 64'(rsb1), 64'h1);
    cyc(5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t4_rsb", 64'(rsb1), 64'h1);
    check("t4_rtb", 64'(rtb1), 64'h1);
    check("t4_cnt", 64'(cnt1), 64'h1);
    check("t4_A",   64'(a1),   64'h77);
    check("t4_B",   64'(b1),   64'h77);
    cyc(5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    cyc(5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t4_reissue_cnt", 64'(cnt1), 64'h1);
    cyc(5'd7, 5'd0, 5'd7, 32'h88, 1'b1, 1'b0, 5'd0);
    cyc(5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t4_final_busy", 64'(rsb1), 64'h0);
    check("t4_final_cnt",  64'(cnt1), 64'h0);
    check("t4_final_A",    64'(a1),   64'h88);

    // Bypass of write data
    cyc(5'd3, 5'd0, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0);
`ifdef BYPASS_EN
    check("t5_bypass_A", 64'(a1), 64'hDEADBEEF);
`else
    check("t5_bypass_A", 64'(a1), 64'h0);
`endif
    cyc(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t5_after_A", 64'(a1), 64'hDEADBEEF);

    // Issue to reg 0: only the ordinary instance tracks it
    cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0);
    cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("r0_cnt_zr",    64'(cnt1), 64'h0);
    check("r0_cnt_plain", 64'(cnt0), 64'h1);
    check("r0_rsb_zr",    64'(rsb1), 64'h0);
    check("r0_rsb_plain", 64'(rsb0), 64'h1);
    cyc(5'd0, 5'd0, 5'd0, 32'h5, 1'b1, 1'b0, 5'd0);
    cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("r0_clr_plain", 64'(cnt0), 64'h0);

    // Fill every register: count reaches DEPTH without wrapping
    for (int i = 0; i < 32; i++) cyc(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 5'(i));
    cyc(5'd31, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("full_cnt_plain", 64'(cnt0), 64'd32);
    check("full_cnt_zr",    64'(cnt1), 64'd31);
    check("full_rsb",       64'(rsb1), 64'h1);
    for (int i = 0; i < 32; i++) cyc(5'(i), 5'd0, 5'(i), 32'(i * 3 + 1), 1'b1, 1'b0, 5'd0);
    cyc(5'd31, 5'd9, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("drain_cnt_plain", 64'(cnt0), 64'd0);
    check("drain_cnt_zr",    64'(cnt1), 64'd0);
    check("drain_A",         64'(a1),   64'd94);
    check("drain_B",         64'(b1),   64'd28);

    // Async reset between edges
    cyc(5'd0, 5'd0, 5'd1, 32'h11, 1'b1, 1'b0, 5'd0);
    cyc(5'd0, 5'd0, 5'd2, 32'h22, 1'b1, 1'b1, 5'd2);
    cyc(5'd0, 5'd0, 5'd3, 32'h33, 1'b1, 1'b0, 5'd0);
    cyc(5'd0, 5'd0, 5'd4, 32'h44, 1'b1, 1'b1, 5'd3);
    cyc(5'd1, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t6_pre_A",   64'(a1),   64'h11);
    check("t6_pre_B",   64'(b1),   64'h22);
    check("t6_pre_rtb", 64'(rtb1), 64'h1);
    check("t6_pre_cnt", 64'(cnt1), 64'h2);
    rs = 5'd2; rt = 5'd3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_A",   64'(a1),   64'h0);
    check("t6_rst_B",   64'(b1),   64'h0);
    check("t6_rst_rsb", 64'(rsb1), 64'h0);
    check("t6_rst_rtb", 64'(rtb1), 64'h0);
    check("t6_rst_cnt", 64'(cnt1), 64'h0);
    // Traffic during reset must be discarded
    cyc(5'd1, 5'd5, 5'd1, 32'h99, 1'b1, 1'b1, 5'd5);
    check("t6_inrst_A", 64'(a1), 64'h0);
    cyc(5'd1, 5'd5, 5'd1, 32'h99, 1'b1, 1'b1, 5'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    regWrite = 1'b0; issue_valid = 1'b0;
    cyc(5'd1, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    check("t6_post_A",   64'(a1),   64'h0);
    check("t6_post_rtb", 64'(rtb1), 64'h0);
    check("t6_post_cnt", 64'(cnt1), 64'h0);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
